gb_psum_bank: RTL and testbench
===============================

# gb_psum_bank

Global-buffer-side partial-sum bank serving one PEB psum channel. It is the GB end of the PEB psum handshake pair. On each feature-group pass it streams stored psums to the PEB over GBPSUM, or all-zero psums on the first pass. It then captures the accumulated psums the PEB sends back over PSUMGB into the same entries. A host read port drains final results between passes.

## Interface
- PSUM_WIDTH, 32, bits per psum lane (signed)
- NUM_LANE, 16, psum lanes per beat; beat width W = NUM_LANE*PSUM_WIDTH
- DEPTH, 16, beats stored; AW = $clog2(DEPTH)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a pass (sampled only in IDLE)
- cfg_first  in  1  sampled with start: 1 = first pass, return zeros
- cfg_len  in  AW+1  sampled with start: beats this pass, saturated to DEPTH
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse at pass completion
- GBPSUM_val  out  1  GB→PEB psum beat valid
- GBPSUM_data  out  W  GB→PEB psum beat, lane i at [PSUM_WIDTH*i +: PSUM_WIDTH]
- PSUMGB_rdy  in  1  PEB ready for GBPSUM beat
- PSUMGB_val  in  1  PEB→GB accumulated psum beat valid
- PSUMGB_data  in  W  PEB→GB psum beat, same lane packing
- GBPSUM_rdy  out  1  GB ready for PSUMGB beat
- host_rd_en  in  1  host read request (honoured only in IDLE)
- host_rd_addr  in  AW  host read entry
- host_rd_data  out  W  registered host read data

## Operation
- Storage: DEPTH×W flop array, reset to 0. Counters: rd_cnt = beats loaded into the GBPSUM output register; rd_acc = GBPSUM handshakes done; wr_cnt = PSUMGB handshakes done. Latched: first_q, len_q.
- FSM IDLE→RUN on start. RUN→DONE when wr_cnt reaches len_q, including the beat being written. DONE→IDLE unconditionally after 1 cycle, with done=1 during DONE.
- Start with len 0: IDLE→RUN→DONE→IDLE. No beats are exchanged.
- start outside IDLE is ignored. cfg_* are not re-sampled.
- Read stream: the output register loads entry rd_cnt, or 0 if first_q, whenever (!GBPSUM_val || PSUMGB_rdy) and rd_cnt < len_q. It then raises GBPSUM_val and increments rd_cnt. A handshake is GBPSUM_val && PSUMGB_rdy and increments rd_acc. The data holds stable while val && !rdy. val drops once all len_q beats are accepted.
- Write stream: GBPSUM_rdy = RUN && wr_cnt < len_q && (first_q || wr_cnt < rd_acc). This is purely registered, with no combinational path from inputs. On PSUMGB_val && GBPSUM_rdy, mem[wr_cnt] ← PSUMGB_data and wr_cnt increments.
- The gating guarantees entry i is read before it is overwritten. A read and a write to the same entry never occur in the same cycle.
- Host port: host_rd_en in IDLE sets host_rd_data ← mem[host_rd_addr] at the next edge. Otherwise host_rd_data holds its value.
- No arithmetic on data. Beats pass bit-exact; the PEB performs accumulation.

## Timing
- Reset values: busy=0, done=0, GBPSUM_val=0, GBPSUM_data=0, GBPSUM_rdy=0, host_rd_data=0. State is IDLE, all counters 0, mem all 0.
- start at edge T: RUN from T. The first beat is loaded at edge T+1, so GBPSUM_val is high in cycle T+1→T+2. Sustained throughput is 1 beat/cycle each direction with PSUMGB_rdy held high.
- The last write handshake at edge E gives done=1 in cycle E→E+1, then busy=0 one cycle later.
- Reset asserted mid-pass: immediate return to reset values. Partially written mem contents are cleared. No done pulse.
- PSUMGB_val without GBPSUM_rdy: no write and no counter change. PSUMGB_val in IDLE is ignored.

## Test plan
- First pass, cfg_first=1, len=4, PSUMGB_rdy=1: 4 consecutive all-zero GBPSUM beats starting cycle T+1. PEB returns lanes = beat index+1. mem[0..3] hold 1..4 in every lane, and done pulses once.
- Second pass, cfg_first=0, len=4: GBPSUM returns beats 1,2,3,4 in order. Write-back of 10,20,30,40 is followed by host reads of addr 0..3, which return 10,20,30,40 one cycle after each request.
- Backpressure: PSUMGB_rdy toggles 1,0,0,1… GBPSUM_data stays stable while stalled, and no beat is lost or duplicated. Signed lane value 0x8000_0000 passes unchanged.
- Write gating: non-first pass with PSUMGB_rdy=0. GBPSUM_rdy stays 0 despite PSUMGB_val=1, then rises only after the first read handshake.
- len=0 and len=31: len 0 gives done in the cycle after RUN entry with no beats; len 31 saturates to 16 beats. A second start asserted during RUN is ignored.
- Reset mid-pass after 2 of 4 writes: all outputs return to 0. A host read of addr 0 after reset returns 0.

Source files
------------

// File: rtl/gb_psum_bank.sv
// rtl/gb_psum_bank.sv - GB-side psum bank: streams stored psums to the PEB and captures accumulated psums back
module gb_psum_bank #(
    parameter int PSUM_WIDTH = 32,
    parameter int NUM_LANE   = 16,
    parameter int DEPTH      = 16,
    localparam int W         = NUM_LANE * PSUM_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cfg_first,
    input  logic [AW:0]   cfg_len,
    output logic          busy,
    output logic          done,
    output logic          GBPSUM_val,
    output logic [W-1:0]  GBPSUM_data,
    input  logic          PSUMGB_rdy,
    input  logic          PSUMGB_val,
    input  logic [W-1:0]  PSUMGB_data,
    output logic          GBPSUM_rdy,
    input  logic          host_rd_en,
    input  logic [AW-1:0] host_rd_addr,
    output logic [W-1:0]  host_rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_e      state_q, state_d;
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] rd_cnt, rd_acc, wr_cnt, len_q, len_sat, wr_cnt_nxt;
    logic        first_q;
    logic        rd_load, rd_fire, wr_fire, pass_start;

    assign len_sat    = (cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
    assign pass_start = (state_q == IDLE) && start;
    assign rd_load    = (state_q == RUN) && (!GBPSUM_val || PSUMGB_rdy) && (rd_cnt < len_q);
    assign rd_fire    = GBPSUM_val && PSUMGB_rdy;

    // Write-back of entry i waits until entry i has been handed to the PEB,
    // so the read stream never sees an already-overwritten psum.
    assign GBPSUM_rdy = (state_q == RUN) && (wr_cnt < len_q) && (first_q || (wr_cnt < rd_acc));
    assign wr_fire    = PSUMGB_val && GBPSUM_rdy;
    assign wr_cnt_nxt = wr_cnt + {{AW{1'b0}}, wr_fire};

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (wr_cnt_nxt == len_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            first_q      <= 1'b0;
            len_q        <= '0;
            rd_cnt       <= '0;
            rd_acc       <= '0;
            wr_cnt       <= '0;
            GBPSUM_val   <= 1'b0;
            GBPSUM_data  <= '0;
            host_rd_data <= '0;
        end else begin
            state_q <= state_d;
            if (pass_start) begin
                first_q <= cfg_first;
                len_q   <= len_sat;
                rd_cnt  <= '0;
                rd_acc  <= '0;
                wr_cnt  <= '0;
            end else begin
                if (rd_load) rd_cnt <= rd_cnt + ONE_C;
                if (rd_fire) rd_acc <= rd_acc + ONE_C;
                if (wr_fire) wr_cnt <= wr_cnt_nxt;
            end
            if (rd_load) begin
                GBPSUM_val  <= 1'b1;
                GBPSUM_data <= first_q ? '0 : mem[rd_cnt[AW-1:0]];
            end else if (rd_fire) begin
                GBPSUM_val  <= 1'b0;
            end
            if ((state_q == IDLE) && host_rd_en) host_rd_data <= mem[host_rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_fire) begin
            mem[wr_cnt[AW-1:0]] <= PSUMGB_data;
        end
    end

endmodule

// File: tb/tb_gb_psum_bank.sv
// tb/tb_gb_psum_bank.sv - directed self-checking bench for gb_psum_bank
module tb_gb_psum_bank;

    localparam int W = 512;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, cfg_first;
    logic [4:0]   cfg_len;
    logic         busy, done;
    logic         GBPSUM_val, GBPSUM_rdy;
    logic [W-1:0] GBPSUM_data;
    logic         PSUMGB_rdy, PSUMGB_val;
    logic [W-1:0] PSUMGB_data;
    logic         host_rd_en;
    logic [3:0]   host_rd_addr;
    logic [W-1:0] host_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  wv [16];
    logic [31:0]  ws [16];
    logic [W-1:0] rx [32];
    int rx_cnt, done_cnt, done_cyc, first_val_cyc, stall_chg, timed_out;

    gb_psum_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_first    (cfg_first),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .GBPSUM_val   (GBPSUM_val),
        .GBPSUM_data  (GBPSUM_data),
        .PSUMGB_rdy   (PSUMGB_rdy),
        .PSUMGB_val   (PSUMGB_val),
        .PSUMGB_data  (PSUMGB_data),
        .GBPSUM_rdy   (GBPSUM_rdy),
        .host_rd_en   (host_rd_en),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [31:0] v, input logic [31:0] step);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = v + step * 32'(i);
        return b;
    endfunction

    function automatic logic rdy_pat(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic host_read(input logic [3:0] a, output logic [W-1:0] d);
        host_rd_en   = 1'b1;
        host_rd_addr = a;
        tick();
        host_rd_en   = 1'b0;
        d            = host_rd_data;
    endtask

    // Runs one pass as the PEB; records returned beats and timing, no checks here.
    task automatic do_pass(input logic first, input logic [4:0] len, input int nwr,
                           input int mode, input int restart_c);
        int           wr_idx, c;
        logic         prev_stall;
        logic [W-1:0] prev_data;
        rx_cnt = 0; done_cnt = 0; done_cyc = -1; first_val_cyc = -1;
        stall_chg = 0; timed_out = 0; wr_idx = 0; prev_stall = 1'b0; prev_data = '0;
        start = 1'b1; cfg_first = first; cfg_len = len;
        PSUMGB_rdy = rdy_pat(mode, 0); PSUMGB_val = 1'b0;
        tick();
        start = 1'b0;
        c = 1;
        while (1) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (GBPSUM_val && first_val_cyc < 0) first_val_cyc = c;
            if (prev_stall && (!GBPSUM_val || GBPSUM_data !== prev_data)) stall_chg++;
            if (done_cnt > 0 && !busy && !GBPSUM_val) break;
            if (c >= 80) begin
                timed_out = 1;
                break;
            end
            start      = (c == restart_c);
            PSUMGB_rdy = rdy_pat(mode, c);
            if (wr_idx < nwr) begin
                PSUMGB_val  = 1'b1;
                PSUMGB_data = mk(wv[wr_idx], ws[wr_idx]);
            end else begin
                PSUMGB_val  = 1'b0;
                PSUMGB_data = '0;
            end
            if (PSUMGB_val && GBPSUM_rdy) wr_idx++;
            if (GBPSUM_val && PSUMGB_rdy) begin
                if (rx_cnt < 32) rx[rx_cnt] = GBPSUM_data;
                rx_cnt++;
            end
            prev_stall = GBPSUM_val && !PSUMGB_rdy;
            prev_data  = GBPSUM_data;
            tick();
            c++;
        end
        start = 1'b0; PSUMGB_val = 1'b0; PSUMGB_rdy = 1'b0; PSUMGB_data = '0;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        rst_n = 1'b0; start = 1'b0; cfg_first = 1'b0; cfg_len = '0;
        PSUMGB_rdy = 1'b0; PSUMGB_val = 1'b0; PSUMGB_data = '0;
        host_rd_en = 1'b0; host_rd_addr = '0;
        tick();
        tick();
        n_cmp++;
        if ({busy, done, GBPSUM_val, GBPSUM_rdy} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, done, GBPSUM_val, GBPSUM_rdy});
        end
        n_cmp++;
        if ({GBPSUM_data, host_rd_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %0h want 0", {GBPSUM_data, host_rd_data});
        end
        rst_n = 1'b1;
        tick();
        host_read(4'd5, d);
        n_cmp++;
        if (d !== '0) begin
            n_err++;
            $display("FAIL reset_mem: got %0h want 0", d);
        end
    endtask

    task automatic test_first_pass();
        logic [W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            wv[i] = 32'(i + 1);
            ws[i] = 32'd0;
        end
        do_pass(1'b1, 5'd4, 4, 0, -1);
        n_cmp++;
        if (timed_out != 0 || rx_cnt != 4) begin
            n_err++;
            $display("FAIL first_beats: got cnt %0d to %0d want cnt 4 to 0", rx_cnt, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx[i] !== '0) begin
                n_err++;
                $display("FAIL first_zero[%0d]: got %0h want 0", i, rx[i]);
            end
        end
        n_cmp++;
        if (first_val_cyc != 2) begin
            n_err++;
            $display("FAIL first_latency: got %0d want 2", first_val_cyc);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 5) begin
            n_err++;
            $display("FAIL first_done: got cnt %0d cyc %0d want cnt 1 cyc 5", done_cnt, done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(4'(i), d);
            n_cmp++;
            if (d !== mk(32'(i + 1), 32'd0)) begin
                n_err++;
                $display("FAIL first_mem[%0d]: got %0h want %0h", i, d, mk(32'(i + 1), 32'd0));
            end
        end
    endtask

    task automatic test_second_pass();
        logic [W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            wv[i] = 32'(10 * (i + 1));
            ws[i] = 32'd0;
        end
        do_pass(1'b0, 5'd4, 4, 0, -1);
        n_cmp++;
        if (timed_out != 0 || rx_cnt != 4) begin
            n_err++;
            $display("FAIL second_beats: got cnt %0d to %0d want cnt 4 to 0", rx_cnt, timed_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx[i] !== mk(32'(i + 1), 32'd0)) begin
                n_err++;
                $display("FAIL second_rx[%0d]: got %0h want %0h", i, rx[i], mk(32'(i + 1), 32'd0));
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 7) begin
            n_err++;
            $display("FAIL second_done: got cnt %0d cyc %0d want cnt 1 cyc 7", done_cnt, done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            host_read(4'(i), d);
            n_cmp++;
            if (d !== mk(32'(10 * (i + 1)), 32'd0)) begin
                n_err++;
                $display("FAIL second_mem[%0d]: got %0h want %0h", i, d, mk(32'(10 * (i + 1)), 32'd0));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        wv[0] = 32'h8000_0000; ws[0] = 32'd0;
        wv[1] = 32'h0000_0100; ws[1] = 32'd1;
        wv[2] = 32'hFFFF_FFFF; ws[2] = 32'd0;
        wv[3] = 32'h7FFF_FFFF; ws[3] = 32'd0;
        do_pass(1'b0, 5'd4, 4, 1, -1);
        n_cmp++;
        if (timed_out != 0 || rx_cnt != 4 || done_cnt != 1) begin
            n_err++;
            $display("FAIL bp_count: got cnt %0d to %0d done %0d want 4 0 1", rx_cnt, timed_out, done_cnt);
        end
        n_cmp++;
        if (stall_chg != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d changes want 0", stall_chg);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx[i] !== mk(32'(10 * (i + 1)), 32'd0)) begin
                n_err++;
                $display("FAIL bp_rx[%0d]: got %0h want %0h", i, rx[i], mk(32'(10 * (i + 1)), 32'd0));
            end
        end
        for (int i = 0; i < 4; i++) begin
            host_read(4'(i), d);
            n_cmp++;
            if (d !== mk(wv[i], ws[i])) begin
                n_err++;
                $display("FAIL bp_mem[%0d]: got %0h want %0h", i, d, mk(wv[i], ws[i]));
            end
        end
    endtask

    task automatic test_write_gating();
        int   highs, c;
        logic seen_done;
        PSUMGB_val = 1'b1; PSUMGB_data = mk(32'h77, 32'd0); PSUMGB_rdy = 1'b0;
        tick();
        n_cmp++;
        if (GBPSUM_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL gate_idle: got %b want 0", GBPSUM_rdy);
        end
        start = 1'b1; cfg_first = 1'b0; cfg_len = 5'd2;
        tick();
        start = 1'b0;
        highs = 0;
        for (int i = 1; i <= 5; i++) begin
            if (GBPSUM_rdy !== 1'b0) highs++;
            if (i < 5) tick();
        end
        n_cmp++;
        if (highs != 0) begin
            n_err++;
            $display("FAIL gate_hold: got %0d cycles high want 0", highs);
        end
        n_cmp++;
        if (GBPSUM_val !== 1'b1 || GBPSUM_data !== mk(32'h8000_0000, 32'd0)) begin
            n_err++;
            $display("FAIL gate_beat0: got val %b data %0h want 1 %0h", GBPSUM_val, GBPSUM_data, mk(32'h8000_0000, 32'd0));
        end
        PSUMGB_rdy = 1'b1;
        tick();
        n_cmp++;
        if (GBPSUM_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL gate_rise: got %b want 1", GBPSUM_rdy);
        end
        seen_done = 1'b0;
        c = 0;
        while (!seen_done && c < 20) begin
            if (done) seen_done = 1'b1;
            tick();
            c++;
        end
        n_cmp++;
        if (!seen_done) begin
            n_err++;
            $display("FAIL gate_done: got no done want done within 20 cycles");
        end
        PSUMGB_val = 1'b0; PSUMGB_rdy = 1'b0;
        tick();
    endtask

    task automatic test_len_edges();
        logic [W-1:0] d;
        int           nz;
        start = 1'b1; cfg_first = 1'b0; cfg_len = 5'd0;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({busy, done, GBPSUM_val} !== 3'b100) begin
            n_err++;
            $display("FAIL len0_run: got %b want 100", {busy, done, GBPSUM_val});
        end
        tick();
        n_cmp++;
        if ({busy, done, GBPSUM_val} !== 3'b110) begin
            n_err++;
            $display("FAIL len0_done: got %b want 110", {busy, done, GBPSUM_val});
        end
        tick();
        n_cmp++;
        if ({busy, done, GBPSUM_val} !== 3'b000) begin
            n_err++;
            $display("FAIL len0_idle: got %b want 000", {busy, done, GBPSUM_val});
        end
        for (int i = 0; i < 16; i++) begin
            wv[i] = 32'(i + 100);
            ws[i] = 32'd1;
        end
        do_pass(1'b1, 5'd31, 16, 0, 3);
        n_cmp++;
        if (timed_out != 0 || rx_cnt != 16) begin
            n_err++;
            $display("FAIL len31_beats: got cnt %0d to %0d want cnt 16 to 0", rx_cnt, timed_out);
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 17) begin
            n_err++;
            $display("FAIL len31_done: got cnt %0d cyc %0d want cnt 1 cyc 17", done_cnt, done_cyc);
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (rx[i] !== '0) nz++;
        n_cmp++;
        if (nz != 0) begin
            n_err++;
            $display("FAIL len31_zero: got %0d nonzero beats want 0", nz);
        end
        host_read(4'd15, d);
        n_cmp++;
        if (d !== mk(32'd115, 32'd1)) begin
            n_err++;
            $display("FAIL len31_mem15: got %0h want %0h", d, mk(32'd115, 32'd1));
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [W-1:0] d;
        int           dn;
        host_read(4'd2, d);
        start = 1'b1; cfg_first = 1'b1; cfg_len = 5'd4;
        PSUMGB_val = 1'b1; PSUMGB_data = mk(32'h55, 32'd0); PSUMGB_rdy = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0; PSUMGB_val = 1'b0; PSUMGB_rdy = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, GBPSUM_val, GBPSUM_rdy} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_ctrl: got %b want 0000", {busy, done, GBPSUM_val, GBPSUM_rdy});
        end
        n_cmp++;
        if ({GBPSUM_data, host_rd_data} !== '0) begin
            n_err++;
            $display("FAIL rstmid_data: got %0h want 0", {GBPSUM_data, host_rd_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_err++;
            $display("FAIL rstmid_nodone: got %0d active cycles want 0", dn);
        end
        for (int i = 0; i < 2; i++) begin
            host_read(4'(i), d);
            n_cmp++;
            if (d !== '0) begin
                n_err++;
                $display("FAIL rstmid_mem[%0d]: got %0h want 0", i, d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pass();
        test_second_pass();
        test_backpressure();
        test_write_gating();
        test_len_edges();
        test_reset_mid_pass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
